// File: rtl/panxi_banked_sram.sv
// Two-port, word-interleaved multi-bank SRAM with round-robin arbitration on
// same-bank conflicts, byte-strobed writes and 1- or 2-cycle read latency.
module panxi_banked_sram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int NUM_BANKS  = 2,
    parameter int OUT_REG    = 0
) (
    input  logic                    ACLK,
    input  logic                    ARST,
    input  logic                    P0_REQ,
    input  logic [ADDR_WIDTH-1:0]   P0_ADDR,
    input  logic                    P0_WE,
    input  logic [DATA_WIDTH/8-1:0] P0_BE,
    input  logic [DATA_WIDTH-1:0]   P0_WDATA,
    output logic                    P0_GNT,
    output logic                    P0_RVALID,
    output logic [DATA_WIDTH-1:0]   P0_RDATA,
    input  logic                    P1_REQ,
    input  logic [ADDR_WIDTH-1:0]   P1_ADDR,
    input  logic                    P1_WE,
    input  logic [DATA_WIDTH/8-1:0] P1_BE,
    input  logic [DATA_WIDTH-1:0]   P1_WDATA,
    output logic                    P1_GNT,
    output logic                    P1_RVALID,
    output logic [DATA_WIDTH-1:0]   P1_RDATA
);
    localparam int BANK_BITS = $clog2(NUM_BANKS);
    localparam int ROW_BITS  = ADDR_WIDTH - BANK_BITS;
    localparam int BYTES     = DATA_WIDTH / 8;
    localparam int DEPTH     = 1 << ROW_BITS;

    logic                  req    [2];
    logic                  we     [2];
    logic [BYTES-1:0]      be     [2];
    logic [DATA_WIDTH-1:0] wdata  [2];
    logic [BANK_BITS-1:0]  bank   [2];
    logic [ROW_BITS-1:0]   row    [2];
    logic                  gnt    [2];
    logic                  rvalid [2];
    logic [DATA_WIDTH-1:0] rdata  [2];
    logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];
    logic                  conflict;
    logic                  prio_reg;

    assign req[0]   = P0_REQ;
    assign req[1]   = P1_REQ;
    assign we[0]    = P0_WE;
    assign we[1]    = P1_WE;
    assign be[0]    = P0_BE;
    assign be[1]    = P1_BE;
    assign wdata[0] = P0_WDATA;
    assign wdata[1] = P1_WDATA;
    assign bank[0]  = P0_ADDR[BANK_BITS-1:0];
    assign bank[1]  = P1_ADDR[BANK_BITS-1:0];
    assign row[0]   = P0_ADDR[ADDR_WIDTH-1:BANK_BITS];
    assign row[1]   = P1_ADDR[ADDR_WIDTH-1:BANK_BITS];

    // prio_reg names the port that wins the next same-bank conflict.
    assign conflict = req[0] && req[1] && (bank[0] == bank[1]);
    assign gnt[0]   = !ARST && req[0] && (!conflict || !prio_reg);
    assign gnt[1]   = !ARST && req[1] && (!conflict || prio_reg);

    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            prio_reg <= 1'b0;
        end else if (conflict) begin
            prio_reg <= !prio_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            logic [DATA_WIDTH-1:0] mem [DEPTH];
            logic [DATA_WIDTH-1:0] rdata_reg;
            logic                  hit0;
            logic                  hit1;
            logic                  sel;
            logic                  wr_en;
            logic                  rd_en;
            logic [ROW_BITS-1:0]   row_sel;

            // Arbitration guarantees at most one granted port per bank.
            assign hit0    = gnt[0] && (bank[0] == BANK_BITS'(gi));
            assign hit1    = gnt[1] && (bank[1] == BANK_BITS'(gi));
            assign sel     = hit1;
            assign row_sel = row[sel];
            assign wr_en   = (hit0 || hit1) && we[sel];
            assign rd_en   = (hit0 || hit1) && !we[sel];

            always_ff @(posedge ACLK) begin
                if (wr_en) begin
                    for (int k = 0; k < BYTES; k++) begin
                        if (be[sel][k]) begin
                            mem[row_sel][k*8 +: 8] <= wdata[sel][k*8 +: 8];
                        end
                    end
                end
                if (rd_en) begin
                    rdata_reg <= mem[row_sel];
                end
            end

            assign bank_rdata[gi] = rdata_reg;
        end

        for (gi = 0; gi < 2; gi++) begin : g_port
            logic                  s1_valid_reg;
            logic [BANK_BITS-1:0]  s1_bank_reg;
            logic [DATA_WIDTH-1:0] s1_data;

            always_ff @(posedge ACLK or posedge ARST) begin
                if (ARST) begin
                    s1_valid_reg <= 1'b0;
                    s1_bank_reg  <= '0;
                end else begin
                    s1_valid_reg <= gnt[gi] && !we[gi];
                    if (gnt[gi] && !we[gi]) begin
                        s1_bank_reg <= bank[gi];
                    end
                end
            end

            assign s1_data = bank_rdata[s1_bank_reg];

            if (OUT_REG == 0) begin : g_direct
                // Bank read registers are shared, so a local copy holds RDATA idle.
                logic [DATA_WIDTH-1:0] hold_reg;

                always_ff @(posedge ACLK or posedge ARST) begin
                    if (ARST) begin
                        hold_reg <= '0;
                    end else if (s1_valid_reg) begin
                        hold_reg <= s1_data;
                    end
                end

                assign rvalid[gi] = s1_valid_reg;
                assign rdata[gi]  = s1_valid_reg ? s1_data : hold_reg;
            end else begin : g_outreg
                logic                  rvalid_reg;
                logic [DATA_WIDTH-1:0] rdata_reg;

                always_ff @(posedge ACLK or posedge ARST) begin
                    if (ARST) begin
                        rvalid_reg <= 1'b0;
                        rdata_reg  <= '0;
                    end else begin
                        rvalid_reg <= s1_valid_reg;
                        if (s1_valid_reg) begin
                            rdata_reg <= s1_data;
                        end
                    end
                end

                assign rvalid[gi] = rvalid_reg;
                assign rdata[gi]  = rdata_reg;
            end
        end
    endgenerate

    assign P0_GNT    = gnt[0];
    assign P1_GNT    = gnt[1];
    assign P0_RVALID = rvalid[0];
    assign P1_RVALID = rvalid[1];
    assign P0_RDATA  = rdata[0];
    assign P1_RDATA  = rdata[1];
endmodule

// File: tb/tb_panxi_banked_sram.sv
// Scoreboard bench: one instance per read latency, shared randomized stimulus,
// expectations from a word-array memory model and the round-robin grant rule.
module tb_panxi_banked_sram;
    localparam int NB    = 2;
    localparam int WORDS = 64;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        ACLK;
    logic        ARST;
    logic        r_req  [2];
    logic [11:0] r_addr [2];
    logic        r_we   [2];
    logic [3:0]  r_be   [2];
    logic [31:0] r_wd   [2];

    logic        gnt_w [2][2];
    logic        rv_w  [4];
    logic [31:0] rd_w  [4];

    logic [31:0] m_mem [WORDS];
    logic        m_prio;
    exp_t        sb [4][$];
    logic [31:0] last_exp [4];
    exp_t        e_m;

    int cyc         = 0;
    int vectors     = 0;
    int miscompares = 0;

    panxi_banked_sram #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .NUM_BANKS(NB), .OUT_REG(0)) dut0 (
        .ACLK(ACLK), .ARST(ARST),
        .P0_REQ(r_req[0]), .P0_ADDR(r_addr[0]), .P0_WE(r_we[0]), .P0_BE(r_be[0]),
        .P0_WDATA(r_wd[0]), .P0_GNT(gnt_w[0][0]), .P0_RVALID(rv_w[0]), .P0_RDATA(rd_w[0]),
        .P1_REQ(r_req[1]), .P1_ADDR(r_addr[1]), .P1_WE(r_we[1]), .P1_BE(r_be[1]),
        .P1_WDATA(r_wd[1]), .P1_GNT(gnt_w[0][1]), .P1_RVALID(rv_w[1]), .P1_RDATA(rd_w[1])
    );

    panxi_banked_sram #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .NUM_BANKS(NB), .OUT_REG(1)) dut1 (
        .ACLK(ACLK), .ARST(ARST),
        .P0_REQ(r_req[0]), .P0_ADDR(r_addr[0]), .P0_WE(r_we[0]), .P0_BE(r_be[0]),
        .P0_WDATA(r_wd[0]), .P0_GNT(gnt_w[1][0]), .P0_RVALID(rv_w[2]), .P0_RDATA(rd_w[2]),
        .P1_REQ(r_req[1]), .P1_ADDR(r_addr[1]), .P1_WE(r_we[1]), .P1_BE(r_be[1]),
        .P1_WDATA(r_wd[1]), .P1_GNT(gnt_w[1][1]), .P1_RVALID(rv_w[3]), .P1_RDATA(rd_w[3])
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    always @(posedge ACLK) cyc <= cyc + 1;

    // Monitor: stream s = dut*2 + port; pops in order, checks data and arrival cycle.
    always @(negedge ACLK) begin
        for (int s = 0; s < 4; s++) begin
            vectors++;
            if (rv_w[s]) begin
                if (sb[s].size() == 0) begin
                    miscompares++;
                    $display("FAIL rvalid_unexpected s%0d cyc %0d: got rvalid=1 data=%h, want rvalid=0",
                             s, cyc, rd_w[s]);
                end else begin
                    e_m = sb[s].pop_front();
                    if (rd_w[s] !== e_m.data || cyc != e_m.due) begin
                        miscompares++;
                        $display("FAIL rdata s%0d: got %h at cyc %0d, want %h at cyc %0d",
                                 s, rd_w[s], cyc, e_m.data, e_m.due);
                    end
                    last_exp[s] = e_m.data;
                end
            end else begin
                if (rd_w[s] !== last_exp[s]) begin
                    miscompares++;
                    $display("FAIL rdata_hold s%0d cyc %0d: got %h want %h", s, cyc, rd_w[s], last_exp[s]);
                end
                if (sb[s].size() != 0 && sb[s][0].due <= cyc) begin
                    miscompares++;
                    $display("FAIL rvalid_missing s%0d cyc %0d: got rvalid=0, want data %h due cyc %0d",
                             s, cyc, sb[s][0].data, sb[s][0].due);
                    void'(sb[s].pop_front());
                end
            end
        end
    end

    task automatic set_req(input int p, input logic we, input int a,
                           input logic [3:0] be, input logic [31:0] wd);
        r_req[p]  = 1'b1;
        r_we[p]   = we;
        r_addr[p] = 12'(a);
        r_be[p]   = be;
        r_wd[p]   = wd;
    endtask

    task automatic rand_req(input int p);
        if ($urandom_range(4) != 0) begin
            set_req(p, 1'($urandom_range(1)), int'($urandom_range(WORDS - 1)),
                    4'($urandom), $urandom);
        end else begin
            r_req[p] = 1'b0;
        end
    endtask

    // One clock: check grants against the arbitration rule, update the model,
    // then retire granted requests; ungranted ones stay held.
    task automatic step();
        logic conflict;
        logic eg [2];
        exp_t e;
        int   a;
        @(negedge ACLK);
        conflict = r_req[0] && r_req[1] && ((r_addr[0] % NB) == (r_addr[1] % NB));
        eg[0] = r_req[0] && (!conflict || !m_prio);
        eg[1] = r_req[1] && (!conflict || m_prio);
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                vectors++;
                if (gnt_w[d][p] !== eg[p]) begin
                    miscompares++;
                    $display("FAIL gnt dut%0d p%0d cyc %0d: got %b want %b", d, p, cyc, gnt_w[d][p], eg[p]);
                end
            end
        end
        for (int p = 0; p < 2; p++) begin
            if (eg[p]) begin
                a = int'(r_addr[p]);
                if (r_we[p]) begin
                    for (int k = 0; k < 4; k++) begin
                        if (r_be[p][k]) m_mem[a][k*8 +: 8] = r_wd[p][k*8 +: 8];
                    end
                end else begin
                    for (int d = 0; d < 2; d++) begin
                        e.data = m_mem[a];
                        e.due  = cyc + 1 + d;
                        sb[d*2 + p].push_back(e);
                    end
                end
            end
        end
        if (conflict) m_prio = !m_prio;
        @(posedge ACLK);
        #1;
        for (int p = 0; p < 2; p++) begin
            if (eg[p]) r_req[p] = 1'b0;
        end
    endtask

    // Called just after an edge: in-flight reads are dropped, PRIO returns to P0.
    task automatic reset_pulse();
        ARST = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                vectors++;
                if (gnt_w[d][p] !== 1'b0 && r_req[p]) begin
                    miscompares++;
                    $display("FAIL gnt_in_reset dut%0d p%0d: got %b want 0", d, p, gnt_w[d][p]);
                end
            end
        end
        for (int s = 0; s < 4; s++) begin
            sb[s].delete();
            last_exp[s] = '0;
        end
        m_prio = 1'b0;
        #1;
        ARST = 1'b0;
    endtask

    initial begin
        ARST   = 1'b1;
        m_prio = 1'b0;
        for (int s = 0; s < 4; s++) last_exp[s] = '0;
        set_req(0, 1'b0, 0, 4'hF, 32'h0);
        set_req(1, 1'b0, 1, 4'hF, 32'h0);
        repeat (2) @(negedge ACLK);
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                vectors++;
                if (gnt_w[d][p] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL gnt_reset dut%0d p%0d: got %b want 0", d, p, gnt_w[d][p]);
                end
            end
        end
        @(posedge ACLK);
        #1;
        ARST     = 1'b0;
        r_req[0] = 1'b0;
        r_req[1] = 1'b0;

        // Preload the working window, both banks in parallel.
        for (int a = 0; a < WORDS; a += 2) begin
            set_req(0, 1'b1, a, 4'hF, $urandom);
            set_req(1, 1'b1, a + 1, 4'hF, $urandom);
            step();
        end

        set_req(0, 1'b1, 4, 4'hF, 32'hDEADBEEF);
        step();
        set_req(0, 1'b0, 4, 4'h0, 32'h0);
        step();
        set_req(0, 1'b1, 16, 4'hF, 32'h11223344);
        step();
        set_req(0, 1'b1, 16, 4'b0101, 32'hAABBCCDD);
        step();
        set_req(0, 1'b0, 16, 4'h0, 32'h0);
        step();
        set_req(0, 1'b0, 2, 4'h0, 32'h0);
        set_req(1, 1'b0, 3, 4'h0, 32'h0);
        step();
        for (int i = 0; i < 4; i++) begin
            if (!r_req[0]) set_req(0, 1'b0, 0, 4'h0, 32'h0);
            if (!r_req[1]) set_req(1, 1'b0, 2, 4'h0, 32'h0);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            if (!r_req[1]) set_req(1, 1'b0, 2 * i + 1, 4'h0, 32'h0);
            step();
        end

        for (int i = 0; i < 2400; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!r_req[p]) rand_req(p);
            end
            step();
            if (i % 600 == 599) begin
                for (int p = 0; p < 2; p++) begin
                    if (!r_req[p]) set_req(p, 1'b0, int'($urandom_range(WORDS - 1)), 4'h0, 32'h0);
                end
                step();
                reset_pulse();
                if (!r_req[0]) set_req(0, 1'b0, 6, 4'h0, 32'h0);
                if (!r_req[1]) set_req(1, 1'b0, 8, 4'h0, 32'h0);
                step();
            end
        end

        for (int i = 0; i < 8; i++) begin
            step();
        end
        for (int s = 0; s < 4; s++) begin
            vectors++;
            if (sb[s].size() != 0) begin
                miscompares++;
                $display("FAIL drain s%0d: got %0d outstanding reads, want 0", s, sb[s].size());
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/panxi_banked_sram.md
Name: panxi_banked_sram

Overview:
- Multi-bank, two-port on-chip SRAM subsystem.
- Two requesters (P0, P1; typically fetch and load/store) share NUM_BANKS word-interleaved single-port banks.
- Requesters to different banks are served in parallel. Same-bank conflicts are resolved by a round-robin arbiter.
- Provides byte-strobed writes, a request/grant handshake, and a configurable read latency.

Parameters:
- DATA_WIDTH, 32: word width in bits. Must be a multiple of 8.
- ADDR_WIDTH, 12: word address width per port, covering all banks.
- NUM_BANKS, 2: bank count. Power of 2, at least 2.
- OUT_REG, 0: 0 gives read latency 1; 1 adds an output register, giving read latency 2.

Ports:
- ACLK, input, 1: clock. All logic is on the rising edge.
- ARST, input, 1: asynchronous reset, active-high.
- P0_REQ, input, 1: port 0 request valid.
- P0_ADDR, input, ADDR_WIDTH: port 0 word address.
- P0_WE, input, 1: port 0 write; 1 = write, 0 = read.
- P0_BE, input, DATA_WIDTH/8: port 0 byte enables, used for writes only.
- P0_WDATA, input, DATA_WIDTH: port 0 write data.
- P0_GNT, output, 1: port 0 request accepted this cycle (combinational).
- P0_RVALID, output, 1: port 0 read data valid.
- P0_RDATA, output, DATA_WIDTH: port 0 read data.
- P1_REQ, P1_ADDR, P1_WE, P1_BE, P1_WDATA, P1_GNT, P1_RVALID, P1_RDATA: identical to the P0 signals, for port 1.

Behaviour:
- Bank mapping:
  - bank = ADDR[log2(NUM_BANKS)-1:0]
  - row = ADDR[ADDR_WIDTH-1:log2(NUM_BANKS)]
  - Each bank holds 2^(ADDR_WIDTH-log2(NUM_BANKS)) words.
- Handshake:
  - A transfer occurs when REQ=1 and GNT=1 in the same cycle.
  - GNT depends only on the REQ/ADDR values of this cycle and on the priority state.
  - A requester holds REQ, ADDR, WE, BE and WDATA stable until granted.
- Arbitration:
  - Different banks, or only one REQ: every requesting port is granted.
  - Same bank, both REQ: the port named by priority bit PRIO is granted and the other sees GNT=0.
  - After each conflict, PRIO flips to the loser. Non-conflict cycles leave PRIO unchanged.
  - Reset value of PRIO is 0, so P0 wins the first conflict.
- Write:
  - Happens at the granting clock edge.
  - Only bytes with BE[k]=1 are updated.
  - BE=0 with WE=1 is granted and is a no-op.
  - Writes never raise RVALID.
- Read:
  - OUT_REG=0: RVALID=1 and RDATA are valid in the cycle after grant.
  - OUT_REG=1: they appear two cycles after grant.
  - Back-to-back granted reads produce back-to-back RVALID pulses, in order.
  - RDATA holds its last value when RVALID=0.
- Read-after-write:
  - A read granted in the cycle after a write to the same address returns the new data.
  - Simultaneous P0 and P1 access to the same address is always a same-bank conflict, so it is serialized by arbitration.
- Reset (ARST=1, async):
  - P*_GNT=0, P*_RVALID=0, P*_RDATA=0, PRIO=0.
  - Read pipeline stages are cleared.
  - An in-flight read is dropped and never returns RVALID.
  - Memory contents are not reset and are undefined after power-up.
  - Writes are blocked while ARST=1.
- Deassertion: the first grant is possible in the first cycle with ARST=0.
- Address range: all ADDR values are legal. Row wrap-around cannot occur; the address space is exactly covered.

Test Plan:
- P0 writes 0xDEADBEEF to address 0x004 with BE=4'hF. Next cycle P0 reads 0x004 → P0_RVALID one cycle later (OUT_REG=0), P0_RDATA=0xDEADBEEF.
- Byte strobes: write 0x11223344 to 0x010 with BE=4'hF, then 0xAABBCCDD with BE=4'b0101. Read → 0x11BB33DD.
- Parallel access: P0 reads 0x002 (bank 0) while P1 reads 0x003 (bank 1), NUM_BANKS=2 → both GNT=1 the same cycle, both RVALID the next cycle with the correct data.
- Conflict with round-robin: both ports hold reads to bank 0 (0x000, 0x002) for 4 cycles. Grants must run P0, P1, P0, P1, with PRIO alternating and no starvation.
- OUT_REG=1: 3 consecutive P1 reads of 0x001, 0x003, 0x005 → RVALID high for 3 consecutive cycles starting 2 cycles after the first grant, data in order.
- Reset mid-read: a read is granted, then ARST pulses before RVALID would have risen. Expect no RVALID, RDATA=0, and PRIO=0 (next conflict goes to P0). Memory written before reset still reads back the previous value.
